// File: rtl/quad_pkg.sv
`default_nettype none
// ============================================================================
// Package  : quad_pkg
// Brief    : Phase encodings, FSM states and the quadrature edge classifier.
// Revision : 1.0
// ============================================================================
package quad_pkg;

    typedef logic [1:0] phase_t;

    localparam phase_t c_ph_00 = 2'b00;
    localparam phase_t c_ph_01 = 2'b01;
    localparam phase_t c_ph_11 = 2'b11;
    localparam phase_t c_ph_10 = 2'b10;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    typedef struct packed {
        logic valid;
        logic fwd;
        logic illegal;
    } dec_t;

    // Forward order is 00->01->11->10, so the forward successor is {p[0], ~p[1]};
    // a change of both bits at once is a double jump.
    function automatic dec_t decode(input phase_t prev, input phase_t cur);
        dec_t d;
        d.valid   = (cur != prev);
        d.illegal = (cur == (prev ^ 2'b11));
        d.fwd     = d.valid && !d.illegal && (cur == {prev[0], ~prev[1]});
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : sync_filter
// Brief    : Multi-flop synchroniser followed by a run-length glitch filter.
// Revision : 1.0
// ============================================================================
module sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic arst_n,
    input  logic i_din,
    output logic o_level
);

    localparam int c_cnt_w = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_filt;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    // The new level is taken on the FILT_LEN-th consecutive differing sample,
    // so the counter only needs to hold the FILT_LEN-1 samples before it.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
            if (w_synced == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_filt <= w_synced;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_filt;

endmodule
`default_nettype wire

// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
// Module   : quad_decoder
// Brief    : Quadrature decoder producing step/dir/err pulses and a position.
// Revision : 1.0
// ============================================================================
module quad_decoder #(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             a_in,
    input  logic             b_in,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic [CNT_W-1:0] pos
);

    import quad_pkg::*;

    localparam int c_init_cycles = SYNC_STAGES + FILT_LEN;
    localparam int c_init_w      = $clog2(c_init_cycles + 1);
    localparam logic [c_init_w-1:0] c_init_last = c_init_w'(c_init_cycles);

    logic [1:0]          w_raw;
    logic [1:0]          w_filt;
    phase_t              w_phase;
    dec_t                w_dec;

    state_t              r_state,    w_state_nxt;
    logic [c_init_w-1:0] r_init_cnt, w_init_cnt_nxt;
    phase_t              r_prev,     w_prev_nxt;
    logic                r_step,     w_step_nxt;
    logic                r_dir,      w_dir_nxt;
    logic                r_err,      w_err_nxt;
    logic [CNT_W-1:0]    r_pos,      w_pos_nxt;

    assign w_raw = {a_in, b_in};

    for (genvar i = 0; i < 2; i++) begin : g_chan
        sync_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN)
        ) u_sync_filter (
            .clk     (clk),
            .arst_n  (arst_n),
            .i_din   (w_raw[i]),
            .o_level (w_filt[i])
        );
    end

    assign w_phase = w_filt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_prev     <= c_ph_00;
            r_step     <= 1'b0;
            r_dir      <= 1'b0;
            r_err      <= 1'b0;
            r_pos      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
            r_prev     <= w_prev_nxt;
            r_step     <= w_step_nxt;
            r_dir      <= w_dir_nxt;
            r_err      <= w_err_nxt;
            r_pos      <= w_pos_nxt;
        end
    end

    // INIT waits for the filters to settle on the reset-time input levels,
    // then adopts that phase so the first tracked comparison is meaningful.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_prev_nxt     = r_prev;
        w_step_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_dir_nxt      = r_dir;
        w_pos_nxt      = r_pos;
        w_dec          = decode(r_prev, w_phase);

        case (r_state)
            ST_INIT: begin
                if (r_init_cnt == c_init_last) begin
                    w_prev_nxt  = w_phase;
                    w_state_nxt = ST_TRACK;
                end else begin
                    w_init_cnt_nxt = r_init_cnt + 1'b1;
                end
            end
            ST_TRACK: begin
                if (w_dec.valid) begin
                    w_prev_nxt = w_phase;
                    if (w_dec.illegal) begin
                        w_err_nxt = 1'b1;
                    end else if (en) begin
                        w_step_nxt = 1'b1;
                        w_dir_nxt  = w_dec.fwd;
                        w_pos_nxt  = w_dec.fwd ? (r_pos + 1'b1) : (r_pos - 1'b1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase

        if (clr) begin
            w_pos_nxt = '0;
        end
    end

    assign step = r_step;
    assign dir  = r_dir;
    assign err  = r_err;
    assign pos  = r_pos;

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_decoder
// Brief    : Directed bench with an event-queue reference model for quad_decoder.
// Revision : 1.0
// ============================================================================
module tb_quad_decoder;

    localparam int CNT_W       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int FILT_LEN    = 3;
    localparam int LAT         = SYNC_STAGES + FILT_LEN + 1;

    localparam int EV_FWD = 0;
    localparam int EV_REV = 1;
    localparam int EV_ILL = 2;

    logic             clk    = 1'b0;
    logic             arst_n = 1'b0;
    logic             en     = 1'b1;
    logic             clr    = 1'b0;
    logic             a_in   = 1'b1;
    logic             b_in   = 1'b1;
    logic             step;
    logic             dir;
    logic             err;
    logic [CNT_W-1:0] pos;

    quad_decoder #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .en     (en),
        .clr    (clr),
        .a_in   (a_in),
        .b_in   (b_in),
        .step   (step),
        .dir    (dir),
        .err    (err),
        .pos    (pos)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int due;
        int kind;
    } ev_t;

    ev_t              evq[$];
    ev_t              ev;
    int               cyc      = 0;
    logic             en_s     = 1'b0;
    logic             clr_s    = 1'b0;
    int               n_tests  = 0;
    int               n_fail   = 0;
    logic [CNT_W-1:0] m_pos    = '0;
    logic             m_dir    = 1'b0;
    bit               chk_on   = 1'b0;
    int               step_cnt = 0;
    int               err_cnt  = 0;
    logic [1:0]       cur_ph   = 2'b11;
    logic             exp_step;
    logic             exp_err;
    int               sc0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Position of a phase in the forward cycle 00,01,11,10.
    function automatic int ph_idx(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] idx_ph(input int i);
        case (i % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        en_s  <= en;
        clr_s <= clr;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            exp_step = 1'b0;
            exp_err  = 1'b0;
            while (evq.size() > 0 && evq[0].due < cyc) begin
                check("event_due", evq[0].due, cyc);
                void'(evq.pop_front());
            end
            if (evq.size() > 0 && evq[0].due == cyc) begin
                ev = evq.pop_front();
                if (ev.kind == EV_ILL) begin
                    exp_err = 1'b1;
                end else if (en_s) begin
                    exp_step = 1'b1;
                    m_dir    = (ev.kind == EV_FWD);
                    m_pos    = (ev.kind == EV_FWD) ? m_pos + 1'b1 : m_pos - 1'b1;
                end
            end
            if (clr_s) m_pos = '0;
            check("step", int'(step), int'(exp_step));
            check("err",  int'(err),  int'(exp_err));
            check("dir",  int'(dir),  int'(m_dir));
            check("pos",  int'(pos),  int'(m_pos));
            if (step) step_cnt++;
            if (err)  err_cnt++;
        end
    end

    task automatic drive_phase(input logic [1:0] p);
        int d;
        @(posedge clk);
        #2;
        d = (ph_idx(p) - ph_idx(cur_ph) + 4) % 4;
        a_in = p[1];
        b_in = p[0];
        if (d != 0) evq.push_back('{due: cyc + LAT, kind: (d == 1) ? EV_FWD : (d == 3) ? EV_REV : EV_ILL});
        cur_ph = p;
    endtask

    task automatic edge_to(input logic [1:0] p);
        drive_phase(p);
        repeat (9) @(posedge clk);
        #1;
    endtask

    task automatic fwd(input int n);
        for (int i = 0; i < n; i++) edge_to(idx_ph(ph_idx(cur_ph) + 1));
    endtask

    task automatic rev(input int n);
        for (int i = 0; i < n; i++) edge_to(idx_ph(ph_idx(cur_ph) + 3));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with both channels high.
        #12;
        check("rst_step", int'(step), 0);
        check("rst_dir",  int'(dir),  0);
        check("rst_err",  int'(err),  0);
        check("rst_pos",  int'(pos),  0);
        @(posedge clk);
        #2;
        arst_n = 1'b1;
        chk_on = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("init_pos",   int'(pos), 0);
        check("init_steps", step_cnt,  0);
        check("init_errs",  err_cnt,   0);

        // Eight forward edges.
        fwd(8);
        check("fwd_pos",   int'(pos), 8);
        check("fwd_dir",   int'(dir), 1);
        check("fwd_steps", step_cnt,  8);

        // Clear, then reverse through zero and forward back.
        @(posedge clk); #2; clr = 1'b1;
        @(posedge clk); #2; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("clr_pos", int'(pos), 0);
        rev(1); check("rev_pos1", int'(pos), 15); check("rev_dir", int'(dir), 0);
        rev(1); check("rev_pos2", int'(pos), 14);
        rev(1); check("rev_pos3", int'(pos), 13);
        fwd(3); check("wrap_pos", int'(pos), 0);

        // Two-cycle glitch on A must be invisible.
        sc0 = step_cnt;
        @(posedge clk); #2; a_in = ~a_in;
        @(posedge clk); #2; a_in = ~a_in;
        repeat (12) @(posedge clk);
        #1;
        check("glitch_pos",   int'(pos), 0);
        check("glitch_steps", step_cnt,  sc0);
        check("glitch_errs",  err_cnt,   0);

        // Double jump 00 -> 11.
        fwd(2);
        check("pre_ill_pos", int'(pos), 2);
        edge_to(2'b11);
        check("ill_errs", err_cnt,   1);
        check("ill_pos",  int'(pos), 2);

        // Disabled counting keeps tracking phase.
        sc0 = step_cnt;
        @(posedge clk); #2; en = 1'b0;
        fwd(5);
        check("dis_pos",   int'(pos), 2);
        check("dis_steps", step_cnt,  sc0);
        check("dis_dir",   int'(dir), 1);
        en = 1'b1;
        rev(1);
        check("reen_pos", int'(pos), 1);
        check("reen_dir", int'(dir), 0);

        // Clear coincident with a step.
        sc0 = step_cnt;
        drive_phase(idx_ph(ph_idx(cur_ph) + 1));
        repeat (LAT - 1) @(posedge clk);
        #2; clr = 1'b1;
        @(posedge clk);
        #2; clr = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("clrstep_pos",   int'(pos), 0);
        check("clrstep_dir",   int'(dir), 1);
        check("clrstep_steps", step_cnt,  sc0 + 1);

        // Asynchronous reset mid-operation with an edge in flight.
        fwd(3);
        check("pre_rst_pos", int'(pos), 3);
        drive_phase(idx_ph(ph_idx(cur_ph) + 1));
        repeat (2) @(posedge clk);
        #3;
        chk_on = 1'b0;
        arst_n = 1'b0;
        #1;
        check("midrst_pos",  int'(pos),  0);
        check("midrst_step", int'(step), 0);
        check("midrst_dir",  int'(dir),  0);
        check("midrst_err",  int'(err),  0);
        evq.delete();
        m_pos = '0;
        m_dir = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        arst_n = 1'b1;
        chk_on = 1'b1;
        sc0 = step_cnt;
        repeat (12) @(posedge clk);
        #1;
        check("reinit_pos",   int'(pos), 0);
        check("reinit_steps", step_cnt,  sc0);
        check("reinit_errs",  err_cnt,   1);
        fwd(1);
        check("post_rst_pos", int'(pos), 1);
        check("post_rst_dir", int'(dir), 1);

        check("queue_empty", evq.size(), 0);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
